// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin arbiter that gives two requesters shared access to a fixed-latency data bus
module data_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BUS_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_exc,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_exc,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_write,
  input  logic [DATA_W-1:0] bus_read,
  input  logic              bus_exception,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic last, gidx, hold_rw, resp_exc, sel1, grant;
  logic [3:0] cnt;
  always_comb begin
    sel1 = m1_req && (!m0_req || !last);
    grant = resetn && state == IDLE && (m0_req || m1_req);
  end
  assign m0_gnt = grant && !sel1;
  assign m1_gnt = grant && sel1;
  assign busy = state != IDLE;
  assign bus_rw = state == ACCESS && hold_rw;
  assign m0_rvalid = state == DONE && !gidx;
  assign m1_rvalid = state == DONE && gidx;
  assign m0_exc = m0_rvalid && resp_exc;
  assign m1_exc = m1_rvalid && resp_exc;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      gidx <= 1'b0;
      hold_rw <= 1'b0;
      resp_exc <= 1'b0;
      bus_addr <= '0;
      bus_write <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state <= ACCESS;
          gidx <= sel1;
          last <= sel1;
          hold_rw <= sel1 ? m1_rw : m0_rw;
          bus_addr <= sel1 ? m1_addr : m0_addr;
          bus_write <= sel1 ? m1_wdata : m0_wdata;
          cnt <= 4'(BUS_LAT - 1);
        end
        ACCESS: if (cnt == '0) begin
          state <= DONE;
          resp_exc <= bus_exception;
          if (gidx) m1_rdata <= bus_read;
          else m0_rdata <= bus_read;
        end else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
